hazard_stall_ctrl: RTL

- Pipeline hazard and stall controller for the 5-stage MIPS-lite core.
- Sequences the ID/EX pipeline register: hold, bubble or pass. Drives stall and flush to PC and IF/ID, and bubbles EX/MEM.
- Handles three cases: load-use hazards, taken-branch flushes, and multi-cycle EX operations (mult/div) that occupy EX for MC_LATENCY cycles.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS-lite core.
// Detects load-use hazards, flushes on taken branches, and freezes the front
// of the pipeline while a multi-cycle EX op (mult/div) completes. It also
// keeps a saturating count of cycles in which the PC was stalled.
module hazard_stall_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 4,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_mem_to_reg,
    input  logic              ex_regwrite,
    input  logic [4:0]        ex_write_reg,
    input  logic              ex_mc_op,
    input  logic              ex_branch_taken,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              idex_hold,
    output logic              exmem_bubble,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_count
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [PERF_W-1:0]   stall_count_r;

    logic                lu_s;
    logic                pc_stall_s;
    logic                ifid_stall_s;
    logic                ifid_flush_s;
    logic                idex_bubble_s;
    logic                idex_hold_s;
    logic                exmem_bubble_s;

    // A load in EX whose destination is a non-zero register read by the ID instruction.
    assign lu_s = ex_mem_to_reg & ex_regwrite & (ex_write_reg != 5'd0) &
                  ((id_use_rs & (id_rs == ex_write_reg)) |
                   (id_use_rt & (id_rt == ex_write_reg)));

    // Stall/flush/bubble decode from current state, down-counter and hazard inputs.
    always_comb begin
        pc_stall_s     = 1'b0;
        ifid_stall_s   = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_bubble_s  = 1'b0;
        idex_hold_s    = 1'b0;
        exmem_bubble_s = 1'b0;
        case (state_r)
            RUN: begin
                if (ex_branch_taken) begin
                    // Wrong-path instructions in IF/ID and ID are squashed.
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end else if (ex_mc_op) begin
                    // First EX cycle of a mult/div: freeze everything behind it.
                    pc_stall_s     = 1'b1;
                    ifid_stall_s   = 1'b1;
                    idex_hold_s    = 1'b1;
                    exmem_bubble_s = 1'b1;
                end else if (lu_s) begin
                    // One bubble lets the load reach MEM where forwarding covers it.
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end else begin
                    pc_stall_s = 1'b0;
                end
            end
            MC_BUSY: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    pc_stall_s     = 1'b1;
                    ifid_stall_s   = 1'b1;
                    idex_hold_s    = 1'b1;
                    exmem_bubble_s = 1'b1;
                end else begin
                    // Final EX cycle: the result drains into EX/MEM.
                    pc_stall_s = 1'b0;
                end
            end
            default: begin
                pc_stall_s = 1'b0;
            end
        endcase
    end

    // Reset overrides every control output combinationally.
    assign pc_stall     = pc_stall_s     & ~rst;
    assign ifid_stall   = ifid_stall_s   & ~rst;
    assign ifid_flush   = ifid_flush_s   & ~rst;
    assign idex_bubble  = idex_bubble_s  & ~rst;
    assign idex_hold    = idex_hold_s    & ~rst;
    assign exmem_bubble = exmem_bubble_s & ~rst;
    assign mc_busy      = (state_r == MC_BUSY) & ~rst;
    assign stall_count  = stall_count_r;

    // FSM: issue of a multi-cycle op, countdown while busy, return to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (!ex_branch_taken && ex_mc_op) begin
                        state_r <= MC_BUSY;
                        cnt_r   <= CNT_W'(MC_LATENCY - 2);
                    end else begin
                        state_r <= RUN;
                    end
                end
                MC_BUSY: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        // ex_mc_op is still high here; it must not re-issue.
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= RUN;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating performance counter of PC-stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= {PERF_W{1'b0}};
        end else if (pc_stall && (stall_count_r != {PERF_W{1'b1}})) begin
            stall_count_r <= stall_count_r + PERF_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

endmodule
